// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the EX/MEM stage and its load-extension helper.
package mem_stage_pkg;
  localparam int XLEN_DEF = 64;
  localparam int F3_UNS   = 2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_mask = 8'h01;
      SZ_H:    size_mask = 8'h03;
      SZ_W:    size_mask = 8'h0f;
      default: size_mask = 8'hff;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] sz);
    case (sz)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  endfunction
endpackage

// File: rtl/mem_stage_load_extend.sv
// Combinational load alignment: shift the 8-byte word down to the accessed lane, then sign/zero extend.
module load_extend
  import mem_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] ext
);
  logic [XLEN-1:0] sh;

  always_comb begin
    sh = rdata >> {offset, 3'b000};
    case (size)
      SZ_B:    ext = {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
      SZ_H:    ext = {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
      SZ_W:    ext = {{(XLEN-32){~uns & sh[31]}}, sh[31:0]};
      default: ext = sh;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// EX/MEM pipeline register plus valid/ready data-memory access; produces registered MEM/WB data.
// Optional: define MEM_MISALIGN_TRAP_EN to retire misaligned memory ops as exceptions without a request.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 ex_flush,
  input  logic [XLEN-1:0]      ex_alu_result,
  input  logic [XLEN-1:0]      ex_store_data,
  input  logic [XLEN-1:0]      ex_branch_target,
  input  logic                 ex_zero,
  input  logic                 ex_branch,
  input  logic                 ex_memread,
  input  logic                 ex_memwrite,
  input  logic                 ex_regwrite,
  input  logic                 ex_memtoreg,
  input  logic [2:0]           ex_funct3,
  input  logic [REGADDR_W-1:0] ex_rd,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  output logic [7:0]           dmem_wstrb,
  input  logic                 dmem_rsp_valid,
  input  logic [XLEN-1:0]      dmem_rsp_rdata,
  output logic [XLEN-1:0]      exmem_result,
  output logic [REGADDR_W-1:0] exmem_rd,
  output logic                 exmem_regwrite,
  output logic                 br_taken,
  output logic [XLEN-1:0]      br_target,
  output logic                 wb_valid,
  output logic [REGADDR_W-1:0] wb_rd,
  output logic                 wb_regwrite,
  output logic [XLEN-1:0]      wb_data,
  output logic                 wb_exc
);
  state_e                state_q, state_d;
  logic                  vld_q, vld_d, mr_q, mr_d, mw_q, mw_d, rw_q, rw_d, m2r_q, m2r_d;
  logic [XLEN-1:0]       res_q, res_d, sdata_q, sdata_d, tgt_q, tgt_d;
  logic [REGADDR_W-1:0]  rd_q, rd_d;
  logic [2:0]            f3_q, f3_d;
  logic                  br_taken_q, br_taken_d;
  logic                  wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d, wb_exc_q, wb_exc_d;
  logic [REGADDR_W-1:0]  wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d, ld_ext;
  logic                  cap, in_req;

  load_extend #(.XLEN(XLEN)) u_ext (
    .rdata (dmem_rsp_rdata),
    .offset(res_q[2:0]),
    .size  (f3_q[1:0]),
    .uns   (f3_q[F3_UNS]),
    .ext   (ld_ext)
  );

  assign cap = (state_q == IDLE) && ex_valid && !ex_flush;

  always_comb begin
    state_d    = state_q;
    vld_d      = vld_q;   mr_d  = mr_q;  mw_d = mw_q; rw_d = rw_q; m2r_d = m2r_q;
    res_d      = res_q;   sdata_d = sdata_q; tgt_d = tgt_q; rd_d = rd_q; f3_d = f3_q;
    br_taken_d = 1'b0;
    wb_valid_d = 1'b0;
    wb_exc_d   = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_rw_d    = wb_rw_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      IDLE: if (cap) begin
        vld_d = 1'b1; mr_d = ex_memread; mw_d = ex_memwrite; rw_d = ex_regwrite;
        m2r_d = ex_memtoreg; res_d = ex_alu_result; sdata_d = ex_store_data;
        tgt_d = ex_branch_target; rd_d = ex_rd; f3_d = ex_funct3;
        br_taken_d = ex_branch & ex_zero;
        if (ex_memread || ex_memwrite) begin
`ifdef MEM_MISALIGN_TRAP_EN
          if (misaligned(ex_alu_result[2:0], ex_funct3[1:0])) begin
            rw_d = 1'b0;
            wb_valid_d = 1'b1; wb_exc_d = 1'b1; wb_rd_d = ex_rd;
            wb_rw_d = 1'b0; wb_data_d = ex_alu_result;
          end else begin
            state_d = REQ;
          end
`else
          state_d = REQ;
`endif
        end else begin
          wb_valid_d = 1'b1; wb_rd_d = ex_rd; wb_rw_d = ex_regwrite; wb_data_d = ex_alu_result;
        end
      end
      REQ: if (dmem_req_ready) begin
        if (mw_q) begin
          state_d = IDLE;
          wb_valid_d = 1'b1; wb_rd_d = rd_q; wb_rw_d = 1'b0; wb_data_d = res_q;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (dmem_rsp_valid) begin
        state_d = IDLE;
        wb_valid_d = 1'b1; wb_rd_d = rd_q; wb_rw_d = rw_q;
        wb_data_d = m2r_q ? ld_ext : res_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vld_q <= 1'b0; mr_q <= 1'b0; mw_q <= 1'b0; rw_q <= 1'b0; m2r_q <= 1'b0;
      res_q <= '0; sdata_q <= '0; tgt_q <= '0; rd_q <= '0; f3_q <= '0;
      br_taken_q <= 1'b0;
      wb_valid_q <= 1'b0; wb_rw_q <= 1'b0; wb_exc_q <= 1'b0; wb_rd_q <= '0; wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q <= vld_d; mr_q <= mr_d; mw_q <= mw_d; rw_q <= rw_d; m2r_q <= m2r_d;
      res_q <= res_d; sdata_q <= sdata_d; tgt_q <= tgt_d; rd_q <= rd_d; f3_q <= f3_d;
      br_taken_q <= br_taken_d;
      wb_valid_q <= wb_valid_d; wb_rw_q <= wb_rw_d; wb_exc_q <= wb_exc_d;
      wb_rd_q <= wb_rd_d; wb_data_q <= wb_data_d;
    end
  end

  assign in_req         = (state_q == REQ);
  assign ex_ready       = (state_q == IDLE);
  assign dmem_req_valid = in_req;
  assign dmem_we        = in_req & mw_q;
  assign dmem_addr      = {res_q[XLEN-1:3], 3'b000};
  // Lanes shifted past byte 7 fall off the 8-bit strobe and the XLEN-wide data.
  assign dmem_wdata     = sdata_q << {res_q[2:0], 3'b000};
  assign dmem_wstrb     = in_req ? (size_mask(f3_q[1:0]) << res_q[2:0]) : 8'h00;

  // A load's EX/MEM result is its address until it retires, so never forward it.
  assign exmem_result   = res_q;
  assign exmem_rd       = rd_q;
  assign exmem_regwrite = rw_q & vld_q & ~(mr_q & ~mw_q & (state_q != IDLE));

  assign br_taken    = br_taken_q;
  assign br_target   = tgt_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_regwrite = wb_rw_q;
  assign wb_data     = wb_data_q;
  assign wb_exc      = wb_exc_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage: ALU ops, stores, loads, branches, flush, reset mid-access.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_flush, ex_zero, ex_branch;
  logic        ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
  logic [63:0] ex_alu_result, ex_store_data, ex_branch_target;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rsp_rdata;
  logic [7:0]  dmem_wstrb;
  logic [63:0] exmem_result, br_target, wb_data;
  logic [4:0]  exmem_rd, wb_rd;
  logic        exmem_regwrite, br_taken, wb_valid, wb_regwrite, wb_exc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(64), .REGADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_flush(ex_flush),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_branch_target(ex_branch_target), .ex_zero(ex_zero), .ex_branch(ex_branch),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .exmem_result(exmem_result), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .br_taken(br_taken), .br_target(br_target),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .wb_data(wb_data), .wb_exc(wb_exc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [63:0] alu, input logic [63:0] sd, input logic [63:0] tgt,
                        input logic zero, input logic br, input logic mr, input logic mw,
                        input logic rw, input logic m2r, input logic [2:0] f3, input logic [4:0] rd);
    ex_valid = 1'b1; ex_flush = 1'b0;
    ex_alu_result = alu; ex_store_data = sd; ex_branch_target = tgt;
    ex_zero = zero; ex_branch = br; ex_memread = mr; ex_memwrite = mw;
    ex_regwrite = rw; ex_memtoreg = m2r; ex_funct3 = f3; ex_rd = rd;
  endtask

  task automatic clr_ex();
    ex_valid = 1'b0; ex_flush = 1'b0;
    ex_alu_result = '0; ex_store_data = '0; ex_branch_target = '0;
    ex_zero = 1'b0; ex_branch = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_regwrite = 1'b0; ex_memtoreg = 1'b0; ex_funct3 = '0; ex_rd = '0;
  endtask

  // Load issued, accepted at once, response two idle cycles later.
  task automatic do_load(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                         input logic [63:0] rdata, input logic [63:0] exp);
    set_ex(addr, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, f3, 5'd7);
    tick();
    clr_ex();
    chk({tag, "_req_valid"}, {63'h0, dmem_req_valid}, 64'h1);
    chk({tag, "_addr"}, dmem_addr, {addr[63:3], 3'b000});
    chk({tag, "_fwd_off"}, {63'h0, exmem_regwrite}, 64'h0);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk({tag, "_wait_ready"}, {63'h0, ex_ready}, 64'h0);
    tick();
    tick();
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = rdata;
    tick();
    dmem_rsp_valid = 1'b0;
    chk({tag, "_wb_valid"}, {63'h0, wb_valid}, 64'h1);
    chk({tag, "_wb_data"}, wb_data, exp);
    chk({tag, "_wb_rw"}, {63'h0, wb_regwrite}, 64'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
    clr_ex();
    tick(); tick();
    chk("rst_ex_ready", {63'h0, ex_ready}, 64'h1);
    chk("rst_req_valid", {63'h0, dmem_req_valid}, 64'h0);
    chk("rst_wb_valid", {63'h0, wb_valid}, 64'h0);
    chk("rst_exmem_result", exmem_result, 64'h0);
    rst_n = 1'b1;
    tick();

    // ADD
    set_ex(64'h1234, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd5);
    tick();
    clr_ex();
    chk("add_wb_valid", {63'h0, wb_valid}, 64'h1);
    chk("add_wb_data", wb_data, 64'h1234);
    chk("add_wb_rd", {59'h0, wb_rd}, 64'd5);
    chk("add_exmem_result", exmem_result, 64'h1234);
    chk("add_exmem_rw", {63'h0, exmem_regwrite}, 64'h1);
    tick();
    chk("add_pulse_end", {63'h0, wb_valid}, 64'h0);

    // Three back-to-back ALU ops
    for (int i = 1; i <= 3; i++) begin
      set_ex(64'(i * 'h11), 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5'(i));
      tick();
      chk("b2b_wb_valid", {63'h0, wb_valid}, 64'h1);
      chk("b2b_wb_data", wb_data, 64'(i * 'h11));
    end
    clr_ex();

    // SB at 0x1003, memory accepts after two stall cycles
    set_ex(64'h1003, 64'hAB, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0);
    tick();
    clr_ex();
    chk("sb_req_valid", {63'h0, dmem_req_valid}, 64'h1);
    chk("sb_we", {63'h0, dmem_we}, 64'h1);
    chk("sb_addr", dmem_addr, 64'h1000);
    chk("sb_wstrb", {56'h0, dmem_wstrb}, 64'h08);
    chk("sb_wdata", dmem_wdata, 64'hAB00_0000);
    chk("sb_ex_ready", {63'h0, ex_ready}, 64'h0);
    tick();
    chk("sb_stall_addr", dmem_addr, 64'h1000);
    chk("sb_stall_ready", {63'h0, ex_ready}, 64'h0);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk("sb_wb_valid", {63'h0, wb_valid}, 64'h1);
    chk("sb_wb_rw", {63'h0, wb_regwrite}, 64'h0);
    chk("sb_done_req", {63'h0, dmem_req_valid}, 64'h0);
    chk("sb_done_ready", {63'h0, ex_ready}, 64'h1);

    // Loads with sign / zero extension
    do_load("lh",  64'h2006, 3'd1, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    do_load("lhu", 64'h2006, 3'd5, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001);
    do_load("lb",  64'h2003, 3'd0, 64'h0000_0000_F000_0000, 64'hFFFF_FFFF_FFFF_FFF0);
    do_load("lw",  64'h2004, 3'd2, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF);
    do_load("ld",  64'h2000, 3'd3, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    // Response while idle is ignored
    dmem_rsp_valid = 1'b1;
    tick();
    dmem_rsp_valid = 1'b0;
    chk("stray_rsp", {63'h0, wb_valid}, 64'h0);

    // BEQ taken then not taken
    set_ex(64'h0, 64'h0, 64'h400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    tick();
    clr_ex();
    chk("beq_taken", {63'h0, br_taken}, 64'h1);
    chk("beq_target", br_target, 64'h400);
    tick();
    chk("beq_pulse_end", {63'h0, br_taken}, 64'h0);
    set_ex(64'h55, 64'h0, 64'h400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    tick();
    clr_ex();
    chk("bne_not_taken", {63'h0, br_taken}, 64'h0);

    // Flushed offer is not captured
    set_ex(64'h999, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd9);
    ex_flush = 1'b1;
    tick();
    clr_ex();
    chk("flush_wb_valid", {63'h0, wb_valid}, 64'h0);
    chk("flush_exmem_hold", exmem_result, 64'h55);

    // Reset while waiting for load data
    set_ex(64'h2000, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 5'd4);
    tick();
    clr_ex();
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk("rstw_in_wait", {63'h0, ex_ready}, 64'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstw_ex_ready", {63'h0, ex_ready}, 64'h1);
    chk("rstw_req_valid", {63'h0, dmem_req_valid}, 64'h0);
    chk("rstw_exmem", exmem_result, 64'h0);
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 64'hDEAD;
    tick();
    dmem_rsp_valid = 1'b0;
    chk("rstw_late_rsp", {63'h0, wb_valid}, 64'h0);

`ifdef MEM_MISALIGN_TRAP_EN
    set_ex(64'h3002, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 5'd9);
    tick();
    clr_ex();
    chk("trap_req_valid", {63'h0, dmem_req_valid}, 64'h0);
    chk("trap_wb_valid", {63'h0, wb_valid}, 64'h1);
    chk("trap_wb_exc", {63'h0, wb_exc}, 64'h1);
    chk("trap_wb_rw", {63'h0, wb_regwrite}, 64'h0);
    chk("trap_wb_data", wb_data, 64'h3002);
`else
    // Misaligned SD is issued as-is; upper lanes drop off
    set_ex(64'h1004, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 5'd0);
    tick();
    clr_ex();
    chk("mis_req_valid", {63'h0, dmem_req_valid}, 64'h1);
    chk("mis_wstrb", {56'h0, dmem_wstrb}, 64'hF0);
    chk("mis_wdata", dmem_wdata, 64'h5566_7788_0000_0000);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    chk("mis_wb_valid", {63'h0, wb_valid}, 64'h1);
    chk("mis_wb_exc", {63'h0, wb_exc}, 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- EX/MEM pipeline register plus data-memory access stage, directly downstream of the execute stage.
- Captures the ALU result, forwarded store data, branch target and control bits from execute.
- Runs a valid/ready data-memory transaction for loads and stores, and produces registered writeback data for MEM/WB.
- Drives the EX/MEM forwarding result back to execute's forwarding muxes and asserts back-pressure while a memory access is outstanding.

Parameters:
- XLEN, 64, datapath width
- REGADDR_W, 5, register index width

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage can accept (state==IDLE)
- ex_flush  in  1  discard the instruction offered this cycle
- ex_alu_result  in  XLEN  ALU result / memory address
- ex_store_data  in  XLEN  forwarded rs2 value
- ex_branch_target  in  XLEN  adder output (pc + imm<<1)
- ex_zero  in  1  ALU zero flag
- ex_branch, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg  in  1 each  control bits
- ex_funct3  in  3  access size/sign
- ex_rd  in  REGADDR_W  destination register
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_we  out  1  1 = store
- dmem_addr  out  XLEN  8-byte-aligned address (addr & ~7)
- dmem_wdata  out  XLEN  store data shifted to byte lane
- dmem_wstrb  out  8  byte enables
- dmem_rsp_valid  in  1  load data valid
- dmem_rsp_rdata  in  XLEN  aligned 8-byte word
- exmem_result  out  XLEN  registered ALU result, for forwarding
- exmem_rd  out  REGADDR_W  registered rd
- exmem_regwrite  out  1  registered regwrite & captured-valid
- br_taken  out  1  one-cycle pulse: branch & zero
- br_target  out  XLEN  registered branch target
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_rd  out  REGADDR_W
- wb_regwrite  out  1
- wb_data  out  XLEN  extended load data, or ALU result
- wb_exc  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; all outputs and registers 0. Any in-flight request or response is abandoned; dmem_req_valid is 0 from the next cycle.
- States: IDLE, REQ, WAIT.
- Capture occurs when state==IDLE, ex_valid=1 and ex_flush=0. With ex_flush=1, nothing is captured and no pulse is produced.
- Non-memory op captured at edge N: wb_valid=1 during cycle N+1 with wb_data=alu_result; state stays IDLE. Throughput is 1/cycle.
- Branch: br_taken and br_target are valid in cycle N+1 only.
- Memory op: IDLE->REQ. In REQ, dmem_req_valid=1 and all dmem_* outputs stay stable until dmem_req_ready.
- Store handshake: ->IDLE; wb_valid pulses next cycle with wb_regwrite=0.
- Load handshake: ->WAIT. On dmem_rsp_valid: ->IDLE; wb_valid next cycle with extended data.
- dmem_rsp_valid outside WAIT is ignored. Memory latency is ≥1 cycle after acceptance.
- memread and memwrite both set: treated as store.
- Size from funct3[1:0]: 0=B, 1=H, 2=W, 3=D. funct3[2]=1 means zero-extend, else sign-extend.
- Byte offset is addr[2:0]. wstrb = size mask << offset. wdata = store_data << (8*offset). Load data = rdata >> (8*offset), then extended.
- exmem_* outputs hold the last captured instruction. exmem_regwrite is forced 0 while state!=IDLE for loads, so execute never forwards an address as load data.
- ex_flush during REQ/WAIT has no effect on the in-flight access.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a memory op whose offset is not a multiple of its size skips REQ entirely. wb_valid pulses in cycle N+1 with wb_exc=1, wb_regwrite=0, wb_data=address.
- Undefined: the access is issued unchanged; byte lanes past bit 63 are dropped; wb_exc is tied 0.

Decomposition:
- Package mem_stage_pkg: state enum (IDLE/REQ/WAIT), size constants SZ_B/SZ_H/SZ_W/SZ_D, funct3 sign bit index, XLEN default.
- Sub-module load_extend (combinational): inputs are rdata, offset, size and unsigned flag; output is XLEN extended value. Shared with any future cache path.

Test Plan:
- ADD, alu_result=0x1234, rd=5, regwrite=1 -> next cycle wb_valid=1, wb_data=0x1234, exmem_result=0x1234. Three back-to-back ops retire on 3 consecutive cycles.
- SB, addr=0x1003, data=0xAB, req_ready after 2 cycles -> dmem_addr=0x1000, wstrb=0x08, wdata[31:24]=0xAB; ex_ready=0 until handshake; wb_regwrite=0.
- LH, addr=0x2006, rsp_rdata=0x8001_0000_0000_0000, rsp after 3 cycles -> wb_data=0xFFFF_FFFF_FFFF_8001. Same access as LHU -> 0x8001.
- BEQ with zero=1, target=0x400 -> br_taken=1 for exactly one cycle, br_target=0x400. With zero=0 -> br_taken stays 0.
- ex_flush=1 with ex_valid=1 -> no wb_valid. rst_n=0 while in WAIT -> next cycle state IDLE, dmem_req_valid=0, late rsp_valid ignored.
- With MEM_MISALIGN_TRAP_EN, LW at 0x3002 -> no dmem_req_valid, wb_exc=1, wb_data=0x3002.
